// File: rtl/ewb_mem_arbiter.sv
// ewb_mem_arbiter: shares one physical-memory port between L2 line-fill reads and EWB drain writes.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cache_read_i/cache_addr_i      fill request (held until cache_resp_o) and line address
//   cache_rdata_o/cache_resp_o     fill data (pass-through) and one-cycle done pulse
//   ewb_empty_i/ewb_full_i         EWB occupancy flags
//   ewb_addr_i/ewb_data_i          EWB head entry
//   ewb_yumi_o                     dequeue pulse on write completion
//   ewb_draining_o                 high while the head line is being written
//   pmem_*                         physical-memory command/response port
module ewb_mem_arbiter #(
  parameter int WIDTH = 256,
  parameter int IDLE_THRESH = 4,
  parameter int MAX_READ_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cache_read_i,
  input  logic [31:0]      cache_addr_i,
  output logic [WIDTH-1:0] cache_rdata_o,
  output logic             cache_resp_o,
  input  logic             ewb_empty_i,
  input  logic             ewb_full_i,
  input  logic [31:0]      ewb_addr_i,
  input  logic [WIDTH-1:0] ewb_data_i,
  output logic             ewb_yumi_o,
  output logic             ewb_draining_o,
  output logic             pmem_read_o,
  output logic             pmem_write_o,
  output logic [31:0]      pmem_address_o,
  output logic [WIDTH-1:0] pmem_wdata_o,
  input  logic [WIDTH-1:0] pmem_rdata_i,
  input  logic             pmem_resp_i
);
  localparam int IW = $clog2(IDLE_THRESH + 1);
  localparam int SW = $clog2(MAX_READ_STREAK + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idle_cnt, w_idle_nxt;
  logic [SW-1:0] r_streak_cnt, w_streak_nxt;
  logic [31:0] r_addr_q;
  logic w_idle, w_ne, w_force, w_grant_w, w_grant_r;
  // Forced drains beat fills: full EWB, fill starvation of the EWB, or a fill to the head line
  // (the fill must see the evicted data in memory, so the write goes first).
  assign w_idle = r_state == IDLE;
  assign w_ne = !ewb_empty_i;
  assign w_force = w_ne && (ewb_full_i || r_streak_cnt == SW'(MAX_READ_STREAK) ||
                   (cache_read_i && cache_addr_i[31:5] == ewb_addr_i[31:5]));
  assign w_grant_w = w_idle && (w_force || (!cache_read_i && w_ne && r_idle_cnt >= IW'(IDLE_THRESH)));
  assign w_grant_r = w_idle && !w_force && cache_read_i;
  always_comb begin
    w_next = w_idle ? (w_grant_w ? WRITE : w_grant_r ? READ : IDLE) : (pmem_resp_i ? IDLE : r_state);
    w_idle_nxt = !w_idle ? r_idle_cnt :
                 (w_grant_w || w_grant_r || cache_read_i || !w_ne) ? '0 :
                 (r_idle_cnt == IW'(IDLE_THRESH)) ? r_idle_cnt : r_idle_cnt + IW'(1);
    w_streak_nxt = !w_idle ? r_streak_cnt :
                   (w_grant_w || !w_ne) ? '0 :
                   (w_grant_r && r_streak_cnt != SW'(MAX_READ_STREAK)) ? r_streak_cnt + SW'(1) : r_streak_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idle_cnt <= '0;
      r_streak_cnt <= '0;
      r_addr_q <= '0;
    end else begin
      r_state <= w_next;
      r_idle_cnt <= w_idle_nxt;
      r_streak_cnt <= w_streak_nxt;
      if (w_grant_r) r_addr_q <= cache_addr_i;
    end
  end
  // Write address/data come straight from the EWB head, which only yumi can change.
  assign pmem_read_o = r_state == READ;
  assign pmem_write_o = r_state == WRITE;
  assign pmem_address_o = pmem_read_o ? r_addr_q : pmem_write_o ? ewb_addr_i : '0;
  assign pmem_wdata_o = ewb_data_i;
  assign cache_rdata_o = pmem_rdata_i;
  assign cache_resp_o = pmem_read_o && pmem_resp_i;
  assign ewb_yumi_o = pmem_write_o && pmem_resp_i;
  assign ewb_draining_o = pmem_write_o;
endmodule
